// File: rtl/game_defs.sv
// Shared game definitions: default widths, map cell encoding and player-update FSM states.
// The slide states (StProbeX..StChkY) exist only when WALL_SLIDE_EN is defined.
package game_defs;

    localparam int unsigned DEF_POS_X_W    = 14;
    localparam int unsigned DEF_POS_Y_W    = 13;
    localparam int unsigned DEF_ANGLE_W    = 8;
    localparam int unsigned DEF_DIR_W      = 15;
    localparam int unsigned DEF_CELL_SHIFT = 8;
    localparam int unsigned DEF_GRID_W     = 3;
    localparam int unsigned DEF_TURN_STEP  = 2;
    localparam int unsigned DEF_TICK_DIV   = 1000000;
    localparam int unsigned GRID_EMPTY     = 0;

    typedef enum logic [3:0] {
        StIdle    = 4'd0,
        StCalc    = 4'd1,
        StProbeXy = 4'd2,
        StChkXy   = 4'd3,
`ifdef WALL_SLIDE_EN
        StProbeX  = 4'd4,
        StChkX    = 4'd5,
        StProbeY  = 4'd6,
        StChkY    = 4'd7,
`endif
        StCommit  = 4'd8,
        StDone    = 4'd9
    } motion_state_t;

    typedef enum logic [1:0] {
        MoveNone = 2'd0,
        MoveXy   = 2'd1,
        MoveX    = 2'd2,
        MoveY    = 2'd3
    } move_sel_t;

    // Width at which an unsigned position plus a signed step can never wrap.
    function automatic int unsigned sum_width(input int unsigned pos_w, input int unsigned dir_w);
        return ((pos_w + 1 > dir_w) ? pos_w + 1 : dir_w) + 1;
    endfunction

endpackage

// File: rtl/pos_to_cell.sv
// Maps the upper bits of a widened position sum to a grid cell index and flags any value
// outside [0, 2^POS_W) (negative sums carry set upper bits, so one OR covers both ends).
module pos_to_cell
    import game_defs::*;
#(
    parameter int unsigned POS_W      = DEF_POS_X_W,
    parameter int unsigned SUM_W      = DEF_POS_X_W + 2,
    parameter int unsigned CELL_SHIFT = DEF_CELL_SHIFT
) (
    input  logic [SUM_W-CELL_SHIFT-1:0] i_pos_hi,
    output logic [POS_W-CELL_SHIFT-1:0] o_cell,
    output logic                        o_oob
);

    assign o_cell = i_pos_hi[POS_W-CELL_SHIFT-1:0];
    assign o_oob  = |i_pos_hi[SUM_W-CELL_SHIFT-1:POS_W-CELL_SHIFT];

endmodule

// File: rtl/player_motion_ctrl.sv
// Rate-limited player updater: turn + move, map collision probes, optional wall sliding
// (X then Y probe after a blocked full step) enabled by defining WALL_SLIDE_EN.
module player_motion_ctrl
    import game_defs::*;
#(
    parameter int unsigned POS_X_W    = DEF_POS_X_W,
    parameter int unsigned POS_Y_W    = DEF_POS_Y_W,
    parameter int unsigned ANGLE_W    = DEF_ANGLE_W,
    parameter int unsigned DIR_W      = DEF_DIR_W,
    parameter int unsigned CELL_SHIFT = DEF_CELL_SHIFT,
    parameter int unsigned GRID_W     = DEF_GRID_W,
    parameter int unsigned TURN_STEP  = DEF_TURN_STEP,
    parameter int unsigned TICK_DIV   = DEF_TICK_DIV
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          i_start,
    output logic                          o_done,
    input  logic                          i_turn_right,
    input  logic                          i_turn_left,
    input  logic                          i_move_forward,
    input  logic                          i_move_backward,
    input  logic [POS_X_W-1:0]            i_cur_pos_x,
    input  logic [POS_Y_W-1:0]            i_cur_pos_y,
    input  logic [ANGLE_W-1:0]            i_cur_angle,
    input  logic [DIR_W-1:0]              i_dir_x,
    input  logic [DIR_W-1:0]              i_dir_y,
    output logic [POS_X_W-1:0]            o_next_pos_x,
    output logic [POS_Y_W-1:0]            o_next_pos_y,
    output logic [ANGLE_W-1:0]            o_next_angle,
    output logic [POS_X_W-CELL_SHIFT-1:0] o_grid_x,
    output logic [POS_Y_W-CELL_SHIFT-1:0] o_grid_y,
    input  logic [GRID_W-1:0]             i_grid_out
);

    localparam int unsigned SUM_X_W = sum_width(POS_X_W, DIR_W);
    localparam int unsigned SUM_Y_W = sum_width(POS_Y_W, DIR_W);
    localparam int unsigned CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    motion_state_t                  r_state, w_state_d;
    move_sel_t                      r_sel, w_sel;
    logic [CNT_W-1:0]               r_cnt;
    logic [SUM_X_W-1:0]             r_cand_x, w_cur_x, w_step_x, w_sum_x;
    logic [SUM_Y_W-1:0]             r_cand_y, w_cur_y, w_step_y, w_sum_y;
    logic [ANGLE_W-1:0]             r_cand_angle, w_cand_angle;
    logic                           r_probe_oob;
    logic [POS_X_W-CELL_SHIFT-1:0]  r_grid_x, w_cell_x;
    logic [POS_Y_W-CELL_SHIFT-1:0]  r_grid_y, w_cell_y;
    logic [POS_X_W-1:0]             r_next_x;
    logic [POS_Y_W-1:0]             r_next_y;
    logic [ANGLE_W-1:0]             r_next_angle;
    logic [SUM_X_W-CELL_SHIFT-1:0]  w_probe_x;
    logic [SUM_Y_W-CELL_SHIFT-1:0]  w_probe_y;
    logic                           w_oob_x, w_oob_y, w_move, w_blocked;
    logic                           w_load_cand, w_load_grid, w_commit, w_hold_cur;

    assign w_cur_x  = {{(SUM_X_W-POS_X_W){1'b0}}, i_cur_pos_x};
    assign w_cur_y  = {{(SUM_Y_W-POS_Y_W){1'b0}}, i_cur_pos_y};
    assign w_step_x = {{(SUM_X_W-DIR_W){i_dir_x[DIR_W-1]}}, i_dir_x};
    assign w_step_y = {{(SUM_Y_W-DIR_W){i_dir_y[DIR_W-1]}}, i_dir_y};
    assign w_sum_x  = i_move_forward ? w_cur_x + w_step_x : w_cur_x - w_step_x;
    assign w_sum_y  = i_move_forward ? w_cur_y + w_step_y : w_cur_y - w_step_y;
    assign w_move   = i_move_forward ^ i_move_backward;

    always_comb begin
        w_cand_angle = i_cur_angle;
        if (i_turn_right && !i_turn_left) begin
            w_cand_angle = i_cur_angle + ANGLE_W'(TURN_STEP);
        end else if (i_turn_left && !i_turn_right) begin
            w_cand_angle = i_cur_angle - ANGLE_W'(TURN_STEP);
        end
    end

    // Probe point for the next PROBE state, chosen in the state that precedes it.
    always_comb begin
        w_probe_x = r_cand_x[SUM_X_W-1:CELL_SHIFT];
        w_probe_y = r_cand_y[SUM_Y_W-1:CELL_SHIFT];
        case (r_state)
            StCalc: begin
                w_probe_x = w_sum_x[SUM_X_W-1:CELL_SHIFT];
                w_probe_y = w_sum_y[SUM_Y_W-1:CELL_SHIFT];
            end
`ifdef WALL_SLIDE_EN
            StChkXy: w_probe_y = w_cur_y[SUM_Y_W-1:CELL_SHIFT];
            StChkX:  w_probe_x = w_cur_x[SUM_X_W-1:CELL_SHIFT];
`endif
            default: ;
        endcase
    end

    pos_to_cell #(
        .POS_W      (POS_X_W),
        .SUM_W      (SUM_X_W),
        .CELL_SHIFT (CELL_SHIFT)
    ) u_cell_x (
        .i_pos_hi (w_probe_x),
        .o_cell   (w_cell_x),
        .o_oob    (w_oob_x)
    );

    pos_to_cell #(
        .POS_W      (POS_Y_W),
        .SUM_W      (SUM_Y_W),
        .CELL_SHIFT (CELL_SHIFT)
    ) u_cell_y (
        .i_pos_hi (w_probe_y),
        .o_cell   (w_cell_y),
        .o_oob    (w_oob_y)
    );

    assign w_blocked = (i_grid_out != GRID_W'(GRID_EMPTY)) || r_probe_oob;

    always_comb begin
        w_state_d   = r_state;
        w_sel       = r_sel;
        w_load_cand = 1'b0;
        w_load_grid = 1'b0;
        w_commit    = 1'b0;
        w_hold_cur  = 1'b0;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    if (r_cnt == '0) begin
                        w_state_d = StCalc;
                    end else begin
                        w_state_d  = StDone;
                        w_hold_cur = 1'b1;
                    end
                end
            end
            StCalc: begin
                w_load_cand = 1'b1;
                w_sel       = MoveNone;
                w_load_grid = w_move;
                w_state_d   = w_move ? StProbeXy : StCommit;
            end
            StProbeXy: w_state_d = StChkXy;
            StChkXy: begin
                if (!w_blocked) begin
                    w_sel     = MoveXy;
                    w_state_d = StCommit;
                end else begin
`ifdef WALL_SLIDE_EN
                    w_load_grid = 1'b1;
                    w_state_d   = StProbeX;
`else
                    w_state_d   = StCommit;
`endif
                end
            end
`ifdef WALL_SLIDE_EN
            StProbeX: w_state_d = StChkX;
            StChkX: begin
                if (!w_blocked) begin
                    w_sel     = MoveX;
                    w_state_d = StCommit;
                end else begin
                    w_load_grid = 1'b1;
                    w_state_d   = StProbeY;
                end
            end
            StProbeY: w_state_d = StChkY;
            StChkY: begin
                if (!w_blocked) begin
                    w_sel = MoveY;
                end
                w_state_d = StCommit;
            end
`endif
            StCommit: begin
                w_commit  = 1'b1;
                w_state_d = StDone;
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= StIdle;
            r_sel        <= MoveNone;
            r_cnt        <= '0;
            r_cand_x     <= '0;
            r_cand_y     <= '0;
            r_cand_angle <= '0;
            r_probe_oob  <= 1'b0;
            r_grid_x     <= '0;
            r_grid_y     <= '0;
            r_next_x     <= i_cur_pos_x;
            r_next_y     <= i_cur_pos_y;
            r_next_angle <= i_cur_angle;
        end else begin
            r_state <= w_state_d;
            r_sel   <= w_sel;
            if (w_load_cand) begin
                r_cnt        <= CNT_W'(TICK_DIV - 1);
                r_cand_x     <= w_sum_x;
                r_cand_y     <= w_sum_y;
                r_cand_angle <= w_cand_angle;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_load_grid) begin
                r_grid_x    <= w_cell_x;
                r_grid_y    <= w_cell_y;
                r_probe_oob <= w_oob_x | w_oob_y;
            end
            if (w_hold_cur) begin
                r_next_x     <= i_cur_pos_x;
                r_next_y     <= i_cur_pos_y;
                r_next_angle <= i_cur_angle;
            end else if (w_commit) begin
                r_next_angle <= r_cand_angle;
                r_next_x     <= (r_sel == MoveXy || r_sel == MoveX) ?
                                r_cand_x[POS_X_W-1:0] : i_cur_pos_x;
                r_next_y     <= (r_sel == MoveXy || r_sel == MoveY) ?
                                r_cand_y[POS_Y_W-1:0] : i_cur_pos_y;
            end
        end
    end

    assign o_done       = (r_state == StDone);
    assign o_next_pos_x = r_next_x;
    assign o_next_pos_y = r_next_y;
    assign o_next_angle = r_next_angle;
    assign o_grid_x     = r_grid_x;
    assign o_grid_y     = r_grid_y;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed cases then random moves over a random map, scored
// against an arithmetic model of the update rules. Follows WALL_SLIDE_EN like the design.
module tb_player_motion_ctrl;

    // Long enough that a start issued soon after a short update is rate-limited.
    localparam int unsigned TICK_DIV = 8;

    typedef struct {
        logic [13:0] x;
        logic [12:0] y;
        logic [7:0]  a;
        longint      cyc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic        o_done;
    logic        i_turn_right = 1'b0, i_turn_left = 1'b0;
    logic        i_move_forward = 1'b0, i_move_backward = 1'b0;
    logic [13:0] i_cur_pos_x = '0;
    logic [12:0] i_cur_pos_y = '0;
    logic [7:0]  i_cur_angle = '0;
    logic [14:0] i_dir_x = '0, i_dir_y = '0;
    logic [13:0] o_next_pos_x;
    logic [12:0] o_next_pos_y;
    logic [7:0]  o_next_angle;
    logic [5:0]  o_grid_x;
    logic [4:0]  o_grid_y;
    logic [2:0]  i_grid_out = '0;

    logic [2:0]  map_mem [0:31][0:63];
    exp_t        q[$];
    exp_t        mon_e;
    longint      cyc = 0;
    longint      last_calc = -1000;
    int          n_cmp = 0;
    int          n_err = 0;

    player_motion_ctrl #(
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .i_start         (i_start),
        .o_done          (o_done),
        .i_turn_right    (i_turn_right),
        .i_turn_left     (i_turn_left),
        .i_move_forward  (i_move_forward),
        .i_move_backward (i_move_backward),
        .i_cur_pos_x     (i_cur_pos_x),
        .i_cur_pos_y     (i_cur_pos_y),
        .i_cur_angle     (i_cur_angle),
        .i_dir_x         (i_dir_x),
        .i_dir_y         (i_dir_y),
        .o_next_pos_x    (o_next_pos_x),
        .o_next_pos_y    (o_next_pos_y),
        .o_next_angle    (o_next_angle),
        .o_grid_x        (o_grid_x),
        .o_grid_y        (o_grid_y),
        .i_grid_out      (i_grid_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc        <= cyc + 1;
        i_grid_out <= map_mem[o_grid_y][o_grid_x];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && o_done === 1'b1) begin
            if (q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                mon_e = q.pop_front();
                check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("next_x", 64'(o_next_pos_x), 64'(mon_e.x));
                check("next_y", 64'(o_next_pos_y), 64'(mon_e.y));
                check("next_angle", 64'(o_next_angle), 64'(mon_e.a));
            end
        end
    end

    function automatic bit cell_clear(input int px, input int py);
        if (px < 0 || px >= 16384 || py < 0 || py >= 8192) return 1'b0;
        return map_mem[py / 256][px / 256] == 3'd0;
    endfunction

    task automatic clear_map();
        for (int yy = 0; yy < 32; yy++)
            for (int xx = 0; xx < 64; xx++) map_mem[yy][xx] = 3'd0;
    endtask

    task automatic drive(input int x, input int y, input int a, input int dx, input int dy,
                         input bit r, input bit l, input bit f, input bit b);
        i_cur_pos_x     = 14'(x);
        i_cur_pos_y     = 13'(y);
        i_cur_angle     = 8'(a);
        i_dir_x         = 15'(dx);
        i_dir_y         = 15'(dy);
        i_turn_right    = r;
        i_turn_left     = l;
        i_move_forward  = f;
        i_move_backward = b;
    endtask

    // One update request: the model's result and done cycle go to the scoreboard.
    task automatic issue(input int x, input int y, input int a, input int dx, input int dy,
                         input bit r, input bit l, input bit f, input bit b);
        exp_t   e;
        longint k;
        int     cx, cy, delta;
        @(posedge clock);
        #1;
        drive(x, y, a, dx, dy, r, l, f, b);
        i_start = 1'b1;
        k       = cyc;
        e.x     = 14'(x);
        e.y     = 13'(y);
        e.a     = 8'(a);
        e.cyc   = k + 1;
        if (k + 1 - last_calc >= longint'(TICK_DIV)) begin
            last_calc = k + 2;
            delta     = (r && !l) ? 2 : ((l && !r) ? -2 : 0);
            e.a       = 8'((a + delta) & 255);
            e.cyc     = k + 3;
            if (f != b) begin
                cx    = f ? x + dx : x - dx;
                cy    = f ? y + dy : y - dy;
                e.cyc = k + 5;
                if (cell_clear(cx, cy)) begin
                    e.x = 14'(cx);
                    e.y = 13'(cy);
                end
`ifdef WALL_SLIDE_EN
                else if (cell_clear(cx, y)) begin
                    e.x   = 14'(cx);
                    e.cyc = k + 7;
                end else begin
                    e.cyc = k + 9;
                    if (cell_clear(x, cy)) e.y = 13'(cy);
                end
`endif
            end
        end
        q.push_back(e);
        @(posedge clock);
        #1;
        i_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            if (q.size() == 0) break;
        end
        check("done_timeout", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    initial begin
        int rx, ry, rdx, rdy;
        clear_map();
        drive(16'h0123, 16'h0045, 7, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_done", 64'(o_done), 64'd0);
        check("reset_grid_x", 64'(o_grid_x), 64'd0);
        check("reset_grid_y", 64'(o_grid_y), 64'd0);
        check("reset_next_x", 64'(o_next_pos_x), 64'h0123);
        check("reset_next_y", 64'(o_next_pos_y), 64'h0045);
        check("reset_next_angle", 64'(o_next_angle), 64'd7);

        // Clear move, y-slide around cell (5,4), wrap + combined turn/move.
        issue(16'h0480, 16'h0480, 0, 16, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge clock);
        map_mem[4][5] = 3'd2;
        issue(16'h04F8, 16'h0480, 0, 16, 16, 1'b0, 1'b0, 1'b1, 1'b0);
        map_mem[4][5] = 3'd0;
        repeat (10) @(posedge clock);
        issue(16'h0480, 16'h0480, 255, 16, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge clock);

        // Back-to-back turn-only requests: later ones land inside the rate window.
        for (int i = 0; i < 4; i++) issue(16'h0200, 16'h0300, 10, 5, 5, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (10) @(posedge clock);

        // Underflow off the left edge, then forward+backward cancelling.
        issue(5, 16'h0480, 0, -16, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) @(posedge clock);
        issue(16'h0480, 16'h0480, 0, 16, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (10) @(posedge clock);

        // Reset while in CHK_XY: silent abort, outputs reload from cur_*.
        @(posedge clock);
        #1;
        drive(16'h0600, 16'h0300, 40, 16, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        i_start = 1'b1;
        @(posedge clock);
        #1;
        i_start = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        last_calc = -1000;
        check("abort_next_x", 64'(o_next_pos_x), 64'h0600);
        check("abort_next_y", 64'(o_next_pos_y), 64'h0300);
        check("abort_next_angle", 64'(o_next_angle), 64'd40);
        check("abort_grid_x", 64'(o_grid_x), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("abort_no_done", 64'(o_done), 64'd0);
        end
        issue(16'h0480, 16'h0480, 0, 16, 0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random map and moves; random gaps exercise the rate limiter.
        for (int yy = 0; yy < 32; yy++)
            for (int xx = 0; xx < 64; xx++)
                map_mem[yy][xx] = ($urandom_range(0, 9) < 3) ? 3'($urandom_range(1, 7)) : 3'd0;
        for (int t = 0; t < 160; t++) begin
            rx  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) :
                                                int'($urandom_range(0, 16383));
            ry  = ($urandom_range(0, 3) == 0) ? 8191 - int'($urandom_range(0, 40)) :
                                                int'($urandom_range(0, 8191));
            rdx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 32767)) - 16384 :
                                                int'($urandom_range(0, 600)) - 300;
            rdy = int'($urandom_range(0, 600)) - 300;
            issue(rx, ry, int'($urandom_range(0, 255)), rdx, rdy,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 12)) @(posedge clock);
        end

        repeat (5) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
